// File: rtl/cpu6_csr_exec.sv
// CSR-instruction executor: runs CSRRW/S/C(I) as a fixed read-modify-write on the CSR port, returns old value to writeback.
// Latency: read strobe T+1, write strobe T+2, wb_valid from T+3 (rd!=0); illegal pulse T+1; IDLE T+2 / T+3 / after wb handshake.
// Backpressure: req_ready only in IDLE; WB holds wb_* stable until wb_ready. Optional macro CPU6_CSR_EXEC_IDX_CHK_EN restricts legal indices.
`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif
`ifndef CPU6_CSR_SIZE
`define CPU6_CSR_SIZE 12
`endif

module cpu6_csr_exec (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [2:0]                req_funct3,
  input  logic [`CPU6_CSR_SIZE-1:0] req_csr_idx,
  input  logic [4:0]                req_rs1_idx,
  input  logic [`CPU6_XLEN-1:0]     req_rs1_dat,
  input  logic [4:0]                req_rd_idx,
  output logic                      csr_rd_en,
  output logic                      csr_wr_en,
  output logic [`CPU6_CSR_SIZE-1:0] csr_idx,
  output logic [`CPU6_XLEN-1:0]     csr_write_dat,
  input  logic [`CPU6_XLEN-1:0]     csr_read_dat,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [4:0]                wb_rd_idx,
  output logic [`CPU6_XLEN-1:0]     wb_dat,
  output logic                      illegal_insn
);

  localparam int XLEN = `CPU6_XLEN;
  localparam int CSRW = `CPU6_CSR_SIZE;

  typedef enum logic [2:0] {IDLE, READ, WRITE, WB, ERR} state_t;

  state_t          state;
  logic [2:0]      funct3_r;
  logic [CSRW-1:0] idx_r;
  logic [4:0]      rs1_idx_r;
  logic [XLEN-1:0] rs1_dat_r;
  logic [4:0]      rd_idx_r;
  logic [XLEN-1:0] old_r;
  logic [XLEN-1:0] wdat_r;

  logic            req_wcap;
  logic            req_idx_ok;
  logic            req_legal;
  logic            rd_need;
  logic            wr_need;
  logic            active;
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] rd_data;
  logic [XLEN-1:0] new_val;

  // Legality of the incoming request, evaluated at acceptance.
  always_comb begin
    req_wcap = !(req_funct3[1:0] != 2'b01 && req_rs1_idx == 5'd0);
`ifdef CPU6_CSR_EXEC_IDX_CHK_EN
    req_idx_ok = (req_csr_idx == 12'h304) || (req_csr_idx == 12'h341) ||
                 (req_csr_idx == 12'h344) || (req_csr_idx == 12'h305 && !req_wcap);
`else
    req_idx_ok = 1'b1;
`endif
    req_legal = (req_funct3[1:0] != 2'b00) && req_idx_ok;
  end

  // Operand selection and the new CSR value; computed in READ so the write data is already registered in WRITE.
  always_comb begin
    src     = funct3_r[2] ? {{(XLEN-5){1'b0}}, rs1_idx_r} : rs1_dat_r;
    rd_need = !(funct3_r[1:0] == 2'b01 && rd_idx_r == 5'd0);
    wr_need = !(funct3_r[1:0] != 2'b01 && rs1_idx_r == 5'd0);
    rd_data = rd_need ? csr_read_dat : '0;
    case (funct3_r[1:0])
      2'b10:   new_val = rd_data | src;
      2'b11:   new_val = rd_data & ~src;
      default: new_val = src;
    endcase
  end

  // Strobes decode from state; flush and reset kill them in the current cycle.
  always_comb begin
    active        = reset && !flush;
    req_ready     = (state == IDLE) || !reset;
    csr_rd_en     = active && (state == READ) && rd_need;
    csr_wr_en     = active && (state == WRITE) && wr_need;
    wb_valid      = active && (state == WB);
    illegal_insn  = active && (state == ERR);
    csr_idx       = idx_r;
    csr_write_dat = wdat_r;
    wb_dat        = old_r;
    wb_rd_idx     = rd_idx_r;
  end

  // Sequencer: accept, read, write, writeback; flush returns to IDLE from anywhere.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      funct3_r  <= '0;
      idx_r     <= '0;
      rs1_idx_r <= '0;
      rs1_dat_r <= '0;
      rd_idx_r  <= '0;
      old_r     <= '0;
      wdat_r    <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct3_r  <= req_funct3;
            idx_r     <= req_csr_idx;
            rs1_idx_r <= req_rs1_idx;
            rs1_dat_r <= req_rs1_dat;
            rd_idx_r  <= req_rd_idx;
            state     <= req_legal ? READ : ERR;
          end
        end
        READ: begin
          old_r  <= rd_data;
          wdat_r <= new_val;
          state  <= WRITE;
        end
        WRITE:   state <= (rd_idx_r != 5'd0) ? WB : IDLE;
        WB:      if (wb_ready) state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu6_csr_exec.md
# cpu6_csr_exec

CSR-instruction executor for cpu6: the initiator side of the CSR file's read/write port. It accepts one decoded CSRRW/CSRRS/CSRRC/CSRRWI/CSRRSI/CSRRCI from the execute stage and runs a fixed read-modify-write sequence on csr_rd_en/csr_wr_en/csr_idx/csr_write_dat. It returns the old CSR value to the register-file writeback path and flags illegal encodings to the trap logic.

## Interface
- No parameters. Widths: `CPU6_XLEN` (32), `CPU6_CSR_SIZE` (12).
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  pipeline kill from trap/branch logic.
- req_valid  in  1  request present.
- req_ready  out  1  executor idle; request accepted on valid&ready.
- req_funct3  in  3  instr[14:12].
- req_csr_idx  in  12  instr[31:20].
- req_rs1_idx  in  5  rs1 field; also zimm for the I forms.
- req_rs1_dat  in  XLEN  rs1 register value.
- req_rd_idx  in  5  destination register.
- csr_rd_en, csr_wr_en  out  1  CSR port strobes.
- csr_idx  out  12  CSR index.
- csr_write_dat  out  XLEN  new CSR value.
- csr_read_dat  in  XLEN  combinational read data, valid in the same cycle as csr_rd_en.
- wb_valid  out  1  writeback request.
- wb_ready  in  1  writeback accepted.
- wb_rd_idx  out  5  writeback register.
- wb_dat  out  XLEN  old CSR value.
- illegal_insn  out  1  one-cycle pulse on an illegal request.

## Operation
- FSM states: IDLE, READ, WRITE, WB, ERR. req_ready = (state==IDLE).
- **Accept** (IDLE, valid&ready): register funct3, idx, rs1_idx, rs1_dat, rd_idx.
  - Illegal request (funct3==000 or 100, or index check failure; see Configuration) → ERR.
  - Otherwise → READ.
- **Source operand:** src = funct3[2] ? {27'b0, rs1_idx} : rs1_dat.
- **READ:** csr_rd_en = !(funct3[1:0]==01 && rd_idx==0). Register csr_read_dat into old_r (0 if csr_rd_en is low). → WRITE.
- **WRITE:** compute new value by funct3[1:0]:
  - 01: new = src
  - 10: new = old_r | src
  - 11: new = old_r & ~src
  - csr_wr_en = !(funct3[1:0]!=01 && rs1_idx==0).
  - Next state: WB if rd_idx!=0, else IDLE.
- **WB:** wb_valid=1, wb_dat=old_r, wb_rd_idx=rd_idx. Hold all three stable until wb_ready, then → IDLE.
- **ERR:** illegal_insn=1 for one cycle. No CSR strobes, no writeback. → IDLE.
- csr_idx and csr_write_dat are driven from registers at all times. Strobes are asserted only in READ and WRITE.
- **flush:** from any state, next state is IDLE. The current-cycle csr_rd_en, csr_wr_en, wb_valid and illegal_insn are gated off combinationally. Flush in IDLE blocks acceptance that cycle: req_ready stays 1, but no capture occurs.
- mepc writes race with excp_mepc_ena inside the CSR file, and the exception wins. The executor is not informed, because trap logic asserts flush in the same cycle.

## Timing
- Accept at cycle T. csr_rd_en at T+1, csr_wr_en at T+2, wb_valid from T+3. req_ready returns the cycle after the WB handshake.
- rd==0: IDLE at T+3. Illegal: illegal_insn at T+1, IDLE at T+2.
- Fixed latency: suppressed strobes still consume their state cycle.
- Reset (reset==0 at a clock edge): state IDLE and all registers 0.
  - Output values during reset: req_ready=1 (a request is not captured while reset is asserted); all other outputs 0.
  - Any in-flight request is dropped.

## Configuration
- `CPU6_CSR_EXEC_IDX_CHK_EN` defined: only 0x304, 0x305, 0x341 and 0x344 are legal.
  - Any other index → ERR.
  - A write-capable access to 0x305 (read-only mtvec) → ERR. Write-capable means csr_wr_en would be asserted per the WRITE-state rule.
- Undefined: every index is legal and is issued to the CSR file. Unimplemented CSRs read 0 and writes are dropped there. illegal_insn fires only for bad funct3.

## Test plan
- CSRRW x5, 0x341, rs1_dat=0x8000_0104 with mepc=0x100 → rd_en T+1, wr_en T+2 with csr_write_dat=0x8000_0104, wb_valid T+3 wb_rd_idx=5 wb_dat=0x100.
- CSRRS x0=rs1_idx, 0x304, rd=x7, mie=0x80 → wr_en never asserted; wb_dat=0x80 at T+3. CSRRCI zimm=0x7→ write 0x80 & ~7 = 0x80.
- CSRRW rd=x0 to 0x304, rs1_dat=0x80 → rd_en stays 0, wr_en at T+2, no wb_valid, req_ready=1 at T+3.
- funct3=100 → illegal_insn pulse at T+1, no strobes. With the macro defined, idx=0x300 → the same response. Without the macro, idx=0x300 → normal access with wb_dat=0.
- wb_ready held 0 for 4 cycles → wb_valid, wb_dat and wb_rd_idx stable throughout, req_ready=0; IDLE the cycle after wb_ready=1.
- flush asserted in the WRITE cycle → csr_wr_en=0 that cycle, no wb_valid, IDLE next. reset=0 asserted in READ → all outputs except req_ready read 0 the next cycle.
